// File: rtl/ysyx_22040386_hazard_ctrl.sv
// ysyx_22040386_hazard_ctrl
// Pipeline hazard/stall controller for the 5-stage core. Produces per-stage
// stall/flush enables for load-use bubbles, EX redirects and data-memory
// wait freezes, and runs a watchdog on memory waits that latches a sticky error.
// Optional feature: define YSYX_22040386_HZ_PERF_EN to add the load-use bubble
// and memory-wait performance counters (o_hz_ldu_cnt / o_hz_mwait_cnt).
module ysyx_22040386_hazard_ctrl #(
    parameter int P_TMO_W   = 8,
    parameter int P_TMO_MAX = 200
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_hz_ID_EX_MemRead,
    input  logic [4:0]  i_hz_ID_EX_reg_wr_addr,
    input  logic [4:0]  i_hz_IF_ID_reg_rd_addr1,
    input  logic [4:0]  i_hz_IF_ID_reg_rd_addr2,
    input  logic        i_hz_IF_ID_use_rs1,
    input  logic        i_hz_IF_ID_use_rs2,
    input  logic        i_hz_EX_redirect,
    input  logic        i_hz_dmem_req,
    input  logic        i_hz_dmem_ready,
    output logic        o_hz_PC_stall,
    output logic        o_hz_IF_ID_stall,
    output logic        o_hz_IF_ID_flush,
    output logic        o_hz_ID_EX_stall,
    output logic        o_hz_ID_EX_flush,
    output logic        o_hz_EX_MEM_stall,
    output logic        o_hz_MEM_WB_flush,
`ifdef YSYX_22040386_HZ_PERF_EN
    output logic        o_hz_err,
    output logic [31:0] o_hz_ldu_cnt,
    output logic [31:0] o_hz_mwait_cnt
`else
    output logic        o_hz_err
`endif
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MWAIT = 2'd1,
        S_ERR   = 2'd2
    } state_e;

    localparam logic [P_TMO_W-1:0] L_TMO_MAX = P_TMO_MAX[P_TMO_W-1:0];
    localparam logic [P_TMO_W-1:0] L_ONE     = {{(P_TMO_W-1){1'b0}}, 1'b1};
    localparam logic [P_TMO_W-1:0] L_ZERO    = {P_TMO_W{1'b0}};

    state_e             state_q, state_d;
    logic [P_TMO_W-1:0] cnt_q, cnt_d;

    logic ldu_s;
    logic mwait_s;
    logic ldu_win_s;

    // Hazard detection: load-use that forwarding cannot cover, and memory wait.
    always_comb begin
        ldu_s   = i_hz_ID_EX_MemRead && (i_hz_ID_EX_reg_wr_addr != 5'd0) &&
                  ((i_hz_IF_ID_use_rs1 && (i_hz_IF_ID_reg_rd_addr1 == i_hz_ID_EX_reg_wr_addr)) ||
                   (i_hz_IF_ID_use_rs2 && (i_hz_IF_ID_reg_rd_addr2 == i_hz_ID_EX_reg_wr_addr)));
        mwait_s = i_hz_dmem_req && !i_hz_dmem_ready;
    end

    // Wait FSM state and watchdog counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_RUN;
            cnt_q   <= L_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; counter saturates at the trip value and never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (mwait_s) begin
                    state_d = S_MWAIT;
                    cnt_d   = L_ONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_MWAIT: begin
                if (i_hz_dmem_ready || !i_hz_dmem_req) begin
                    state_d = S_RUN;
                    cnt_d   = L_ZERO;
                end else if (cnt_q == L_TMO_MAX) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + L_ONE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = L_ZERO;
            end
        endcase
    end

    // Prioritised stall/flush decode; everything forced low while reset is held.
    always_comb begin
        o_hz_PC_stall     = 1'b0;
        o_hz_IF_ID_stall  = 1'b0;
        o_hz_IF_ID_flush  = 1'b0;
        o_hz_ID_EX_stall  = 1'b0;
        o_hz_ID_EX_flush  = 1'b0;
        o_hz_EX_MEM_stall = 1'b0;
        o_hz_MEM_WB_flush = 1'b0;
        ldu_win_s         = 1'b0;
        if (!i_rst_n) begin
            ldu_win_s = 1'b0;
        end else if ((state_q == S_ERR) || mwait_s) begin
            // Full freeze: hold every stage up to EX_MEM and bubble MEM_WB.
            o_hz_PC_stall     = 1'b1;
            o_hz_IF_ID_stall  = 1'b1;
            o_hz_ID_EX_stall  = 1'b1;
            o_hz_EX_MEM_stall = 1'b1;
            o_hz_MEM_WB_flush = 1'b1;
        end else if (i_hz_EX_redirect) begin
            // Wrong-path instructions in IF and ID are squashed; any ldu is moot.
            o_hz_IF_ID_flush = 1'b1;
            o_hz_ID_EX_flush = 1'b1;
        end else if (ldu_s) begin
            o_hz_PC_stall    = 1'b1;
            o_hz_IF_ID_stall = 1'b1;
            o_hz_ID_EX_flush = 1'b1;
            ldu_win_s        = 1'b1;
        end else begin
            ldu_win_s = 1'b0;
        end
    end

    assign o_hz_err = (state_q == S_ERR);

`ifdef YSYX_22040386_HZ_PERF_EN
    logic [31:0] ldu_cnt_q;
    logic [31:0] mwait_cnt_q;

    // Performance counters: count inserted bubbles and wait cycles, frozen in error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ldu_cnt_q   <= 32'd0;
            mwait_cnt_q <= 32'd0;
        end else if (state_q != S_ERR) begin
            if (ldu_win_s) begin
                ldu_cnt_q <= ldu_cnt_q + 32'd1;
            end
            if (mwait_s) begin
                mwait_cnt_q <= mwait_cnt_q + 32'd1;
            end
        end
    end

    assign o_hz_ldu_cnt   = ldu_cnt_q;
    assign o_hz_mwait_cnt = mwait_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_22040386_hazard_ctrl.sv
// Self-checking bench for ysyx_22040386_hazard_ctrl (watchdog trip value 4).
// Expected output vectors are queued when stimulus is driven and popped when
// the outputs are sampled on the falling edge.
module tb_ysyx_22040386_hazard_ctrl;

    // {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush, err}
    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_LDU  = 8'b1100_1000;
    localparam logic [7:0] E_RED  = 8'b0010_1000;
    localparam logic [7:0] E_FRZ  = 8'b1101_0110;
    localparam logic [7:0] E_ERR  = 8'b1101_0111;

    typedef struct packed {
        logic       mr;
        logic [4:0] wr;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u1;
        logic       u2;
        logic       rd;
        logic       req;
        logic       rdy;
        logic [7:0] exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       mem_read;
    logic [4:0] wr_addr;
    logic [4:0] rd_addr1;
    logic [4:0] rd_addr2;
    logic       use_rs1;
    logic       use_rs2;
    logic       redirect;
    logic       dmem_req;
    logic       dmem_ready;
    logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic       exmem_stall, memwb_flush, err;
    logic [7:0] outs;
`ifdef YSYX_22040386_HZ_PERF_EN
    logic [31:0] ldu_cnt;
    logic [31:0] mwait_cnt;
`endif

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] cnt_exp_q[$];

    assign outs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                   exmem_stall, memwb_flush, err};

    ysyx_22040386_hazard_ctrl #(
        .P_TMO_W   (8),
        .P_TMO_MAX (4)
    ) dut (
        .i_clk                   (clk),
        .i_rst_n                 (rst_n),
        .i_hz_ID_EX_MemRead      (mem_read),
        .i_hz_ID_EX_reg_wr_addr  (wr_addr),
        .i_hz_IF_ID_reg_rd_addr1 (rd_addr1),
        .i_hz_IF_ID_reg_rd_addr2 (rd_addr2),
        .i_hz_IF_ID_use_rs1      (use_rs1),
        .i_hz_IF_ID_use_rs2      (use_rs2),
        .i_hz_EX_redirect        (redirect),
        .i_hz_dmem_req           (dmem_req),
        .i_hz_dmem_ready         (dmem_ready),
        .o_hz_PC_stall           (pc_stall),
        .o_hz_IF_ID_stall        (ifid_stall),
        .o_hz_IF_ID_flush        (ifid_flush),
        .o_hz_ID_EX_stall        (idex_stall),
        .o_hz_ID_EX_flush        (idex_flush),
        .o_hz_EX_MEM_stall       (exmem_stall),
        .o_hz_MEM_WB_flush       (memwb_flush),
`ifdef YSYX_22040386_HZ_PERF_EN
        .o_hz_err                (err),
        .o_hz_ldu_cnt            (ldu_cnt),
        .o_hz_mwait_cnt          (mwait_cnt)
`else
        .o_hz_err                (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic mr, input logic [4:0] wr, input logic [4:0] r1,
                                input logic [4:0] r2, input logic u1, input logic u2,
                                input logic rd, input logic req, input logic rdy,
                                input logic [7:0] exp);
        vec_t v;
        v.mr = mr; v.wr = wr; v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    // Drive one cycle of stimulus just after the rising edge and queue its expectation.
    task automatic apply_push(input vec_t v);
        @(posedge clk);
        #1;
        mem_read   = v.mr;
        wr_addr    = v.wr;
        rd_addr1   = v.r1;
        rd_addr2   = v.r2;
        use_rs1    = v.u1;
        use_rs2    = v.u2;
        redirect   = v.rd;
        dmem_req   = v.req;
        dmem_ready = v.rdy;
        exp_q.push_back(v.exp);
    endtask

    task automatic idle_inputs();
        mem_read = 1'b0; wr_addr = 5'd0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        use_rs1 = 1'b0; use_rs2 = 1'b0; redirect = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        idle_inputs();
        rst_n = 1'b0;
        dmem_req = 1'b1;
        redirect = 1'b1;
        #12;
        exp_q.push_back(E_NONE);
        exp = exp_q.pop_front();
        if (outs !== exp) begin
            $display("FAIL reset_outputs got=%b exp=%b", outs, exp);
            n_miss++;
        end
        n_vec++;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        vec_t v[$];
        logic [7:0] exp;
        v.push_back(mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_LDU));
        v.push_back(mk(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        v.push_back(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        v.push_back(mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        v.push_back(mk(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_LDU));
        v.push_back(mk(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        v.push_back(mk(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_NONE));
        v.push_back(mk(1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_LDU));
        foreach (v[i]) begin
            apply_push(v[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            if (outs !== exp) begin
                $display("FAIL load_use[%0d] got=%b exp=%b", i, outs, exp);
                n_miss++;
            end
            n_vec++;
        end
    endtask

    task automatic test_redirect();
        vec_t v[$];
        logic [7:0] exp;
        v.push_back(mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_RED));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_RED));
        v.push_back(mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, E_FRZ));
        v.push_back(mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, E_RED));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        foreach (v[i]) begin
            apply_push(v[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            if (outs !== exp) begin
                $display("FAIL redirect[%0d] got=%b exp=%b", i, outs, exp);
                n_miss++;
            end
            n_vec++;
        end
    endtask

    task automatic test_mem_wait();
        vec_t v[$];
        logic [7:0] exp;
        for (int k = 0; k < 3; k++)
            v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE));
        v.push_back(mk(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_LDU));
        // request and ready in the same cycle: no freeze
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        // request withdrawn mid-wait also exits
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_RED));
        // a 4-cycle wait sits just under the trip value of 4
        for (int k = 0; k < 4; k++)
            v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        foreach (v[i]) begin
            apply_push(v[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            if (outs !== exp) begin
                $display("FAIL mem_wait[%0d] got=%b exp=%b", i, outs, exp);
                n_miss++;
            end
            n_vec++;
        end
    endtask

    task automatic test_watchdog();
        vec_t v[$];
        logic [7:0] exp;
        for (int k = 0; k < 5; k++)
            v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_ERR));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_ERR));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ERR));
        v.push_back(mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_ERR));
        foreach (v[i]) begin
            apply_push(v[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            if (outs !== exp) begin
                $display("FAIL watchdog[%0d] got=%b exp=%b", i, outs, exp);
                n_miss++;
            end
            n_vec++;
        end
        // only reset clears the sticky error, and it does so without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(E_NONE);
        exp = exp_q.pop_front();
        if (outs !== exp) begin
            $display("FAIL watchdog_rst got=%b exp=%b", outs, exp);
            n_miss++;
        end
        n_vec++;
        idle_inputs();
        #1;
        rst_n = 1'b1;
        apply_push(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        @(negedge clk);
        exp = exp_q.pop_front();
        if (outs !== exp) begin
            $display("FAIL watchdog_after_rst got=%b exp=%b", outs, exp);
            n_miss++;
        end
        n_vec++;
    endtask

    task automatic test_reset_mid_wait();
        vec_t v[$];
        logic [7:0] exp;
        for (int k = 0; k < 3; k++)
            v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ));
        foreach (v[i]) begin
            apply_push(v[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            if (outs !== exp) begin
                $display("FAIL mid_wait_pre[%0d] got=%b exp=%b", i, outs, exp);
                n_miss++;
            end
            n_vec++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(E_NONE);
        exp = exp_q.pop_front();
        if (outs !== exp) begin
            $display("FAIL mid_wait_rst got=%b exp=%b", outs, exp);
            n_miss++;
        end
        n_vec++;
        idle_inputs();
        #1;
        rst_n = 1'b1;
        // a fresh wait restarts from a cleared counter: 4 wait cycles stay below trip
        v.delete();
        for (int k = 0; k < 4; k++)
            v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        foreach (v[i]) begin
            apply_push(v[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            if (outs !== exp) begin
                $display("FAIL mid_wait_post[%0d] got=%b exp=%b", i, outs, exp);
                n_miss++;
            end
            n_vec++;
        end
    endtask

`ifdef YSYX_22040386_HZ_PERF_EN
    task automatic test_perf();
        vec_t v[$];
        logic [7:0] exp;
        logic [31:0] cexp;
        do_reset();
        v.push_back(mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_LDU));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        v.push_back(mk(1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_LDU));
        v.push_back(mk(1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_RED));
        for (int k = 0; k < 3; k++)
            v.push_back(mk(1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, E_FRZ));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE));
        v.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        foreach (v[i]) begin
            apply_push(v[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            if (outs !== exp) begin
                $display("FAIL perf_seq[%0d] got=%b exp=%b", i, outs, exp);
                n_miss++;
            end
            n_vec++;
        end
        cnt_exp_q.push_back(32'd2);
        cnt_exp_q.push_back(32'd3);
        cexp = cnt_exp_q.pop_front();
        if (ldu_cnt !== cexp) begin
            $display("FAIL perf_ldu_cnt got=%0d exp=%0d", ldu_cnt, cexp);
            n_miss++;
        end
        n_vec++;
        cexp = cnt_exp_q.pop_front();
        if (mwait_cnt !== cexp) begin
            $display("FAIL perf_mwait_cnt got=%0d exp=%0d", mwait_cnt, cexp);
            n_miss++;
        end
        n_vec++;
    endtask
`endif

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_reset_mid_wait();
        test_watchdog();
`ifdef YSYX_22040386_HZ_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ysyx_22040386_hazard_ctrl.md
Name: ysyx_22040386_hazard_ctrl

Overview:
- Pipeline hazard/stall controller for the 5-stage core.
- Sits beside the forwarding control and produces per-stage stall/flush enables for the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Handles four cases: load-use bubbles (not coverable by forwarding), EX-stage redirect flushes, data-memory wait freezes, and a memory-wait watchdog.
- Sequential part: a wait FSM plus timeout counter.

Parameters:
- P_TMO_W, 8, width of memory-wait counter.
- P_TMO_MAX, 200, wait cycles after which the watchdog trips; must satisfy 1 <= P_TMO_MAX <= 2^P_TMO_W-1.

Ports:
- i_clk  in  1  core clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_hz_ID_EX_MemRead  in  1  instruction in EX is a load.
- i_hz_ID_EX_reg_wr_addr  in  5  destination register of instruction in EX.
- i_hz_IF_ID_reg_rd_addr1  in  5  rs1 of instruction in ID.
- i_hz_IF_ID_reg_rd_addr2  in  5  rs2 of instruction in ID.
- i_hz_IF_ID_use_rs1  in  1  ID instruction reads rs1.
- i_hz_IF_ID_use_rs2  in  1  ID instruction reads rs2.
- i_hz_EX_redirect  in  1  branch taken / jump resolved in EX.
- i_hz_dmem_req  in  1  MEM stage has an outstanding load/store.
- i_hz_dmem_ready  in  1  data memory completes the request this cycle.
- o_hz_PC_stall  out  1  hold PC.
- o_hz_IF_ID_stall  out  1  hold IF_ID.
- o_hz_IF_ID_flush  out  1  clear IF_ID to NOP.
- o_hz_ID_EX_stall  out  1  hold ID_EX.
- o_hz_ID_EX_flush  out  1  clear ID_EX to bubble.
- o_hz_EX_MEM_stall  out  1  hold EX_MEM.
- o_hz_MEM_WB_flush  out  1  write a bubble into MEM_WB.
- o_hz_err  out  1  sticky watchdog error.

Behaviour:
- Clock/reset: single clock i_clk; i_rst_n is asynchronous assert, active-low. On reset: FSM = S_RUN, counter = 0, o_hz_err = 0.
- Stall/flush outputs are combinational from FSM state and current inputs. With no hazard (including during reset) all are 0.
- Load-use detect (ldu) = ID_EX_MemRead && wr_addr != 0 && ((use_rs1 && rd_addr1 == wr_addr) || (use_rs2 && rd_addr2 == wr_addr)).
- Memory wait (mwait) = dmem_req && !dmem_ready.
- Output priority, highest first:
  1. S_ERR: PC/IF_ID/ID_EX/EX_MEM stall = 1, MEM_WB_flush = 1, all other outputs 0.
  2. mwait (any state): freeze. PC/IF_ID/ID_EX/EX_MEM stall = 1, MEM_WB_flush = 1. A redirect or ldu is ignored this cycle; it re-presents after the freeze because the stages hold.
  3. EX_redirect: IF_ID_flush = 1, ID_EX_flush = 1, no stalls. Any simultaneous ldu is dropped (wrong-path instruction).
  4. ldu: PC_stall = 1, IF_ID_stall = 1, ID_EX_flush = 1. Exactly one bubble per load; the next cycle the load is in MEM, MEM_WB forwarding covers the dependency, and ldu deasserts naturally.
- FSM (registered):
  - S_RUN: mwait -> S_MWAIT with counter = 1; otherwise stay.
  - S_MWAIT: dmem_ready or !dmem_req -> S_RUN with counter = 0. Else, if counter == P_TMO_MAX -> S_ERR; else counter + 1.
  - S_ERR: absorbing; only reset exits. o_hz_err = 1 while in S_ERR.
- Counter saturates and never wraps.
- Ready arriving in the same cycle as the request: no stall, no state change.
- Reset asserted mid-wait: immediate return to S_RUN, outputs drop combinationally.

Optional Feature:
- Macro: YSYX_22040386_HZ_PERF_EN.
- Defined:
  - Adds outputs o_hz_ldu_cnt[31:0] and o_hz_mwait_cnt[31:0].
  - o_hz_ldu_cnt increments in each cycle where an ldu bubble is actually inserted (priority 4 wins).
  - o_hz_mwait_cnt increments in each cycle where mwait is asserted.
  - Both wrap at 2^32, reset to 0, and freeze in S_ERR.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: MemRead = 1, wr_addr = 5, rd_addr1 = 5, use_rs1 = 1 -> exactly 1 cycle of PC_stall = IF_ID_stall = ID_EX_flush = 1. Same stimulus with wr_addr = 0, or with use_rs1 = 0 -> all outputs 0.
- Redirect + ldu same cycle: EX_redirect = 1 with the ldu condition true -> IF_ID_flush = ID_EX_flush = 1, PC_stall = 0.
- Memory wait: dmem_req = 1, ready low for 3 cycles then high -> 3 cycles of full freeze with MEM_WB_flush = 1, FSM back to S_RUN the cycle after ready, o_hz_err = 0.
- Watchdog: P_TMO_MAX = 4, ready held low -> o_hz_err rises after the 5th wait cycle, stays 1 when ready later rises, clears only on i_rst_n = 0.
- Reset mid-wait: i_rst_n pulsed low asynchronously in S_MWAIT -> outputs go to 0 without waiting for a clock edge, counter = 0.
- With YSYX_22040386_HZ_PERF_EN: 2 ldu bubbles + a 3-cycle wait -> o_hz_ldu_cnt = 2, o_hz_mwait_cnt = 3.
